rc4_prga_param: RTL and testbench

RC4_PRGA_PARAM -- requirements
Module: rc4_prga_param

---
 rtl/rc4_prga_param.sv | 230 +++++++++++++++++++++++
 tb/tb_rc4_prga_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_param.sv
// rc4_prga_param: RC4 keystream generator and decryptor.
// Walks an already-scheduled 256-byte S-box held in an external RAM,
// produces one keystream byte per message byte, XORs it with the
// ciphertext ROM and writes the plaintext to an external RAM.
// All three memories have a fixed read latency of RD_LAT cycles.
// Optional feature macro: PRGA_ASCII_CHECK_EN -- abort with fail when a
// decrypted byte is not a space or a lowercase letter.
module rc4_prga_param #(
  parameter int MSG_LEN_MAX = 32,
  parameter int MSG_AW      = 5,
  parameter int RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MSG_AW:0]   msg_len,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_rddata,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wrdata,
  output logic              dec_wren
);

  // Elaboration-time sanity checks on the configuration.
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("rc4_prga_param: RD_LAT must be in 1..4");
  end
  if ((2 ** MSG_AW) < MSG_LEN_MAX) begin : g_bad_aw
    $error("rc4_prga_param: MSG_AW too small for MSG_LEN_MAX");
  end

  localparam logic [MSG_AW:0] LEN_MAX  = (MSG_AW + 1)'(MSG_LEN_MAX);
  localparam logic [2:0]      WAIT_END = 3'(RD_LAT - 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CALC_I = 4'd1,
    ST_RD_I   = 4'd2,
    ST_WAIT_I = 4'd3,
    ST_RD_J   = 4'd4,
    ST_WAIT_J = 4'd5,
    ST_WR_J   = 4'd6,
    ST_WR_I   = 4'd7,
    ST_RD_F   = 4'd8,
    ST_WAIT_F = 4'd9,
    ST_XOR    = 4'd10,
    ST_WR_D   = 4'd11,
`ifdef PRGA_ASCII_CHECK_EN
    ST_FAIL   = 4'd13,
`endif
    ST_DONE   = 4'd12
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [7:0]      i_reg;
  logic [7:0]      j_reg;
  logic [MSG_AW:0] k_reg;
  logic [MSG_AW:0] len_reg;
  logic [7:0]      si_reg;
  logic [7:0]      sj_reg;
  logic [7:0]      f_reg;
  logic [7:0]      enc_reg;
  logic [7:0]      x_reg;
  logic [2:0]      wait_cnt_reg;

  logic            idle_like;
  logic            start_ok;
  logic [MSG_AW:0] len_clamped;
  logic            wait_last;
  logic            last_byte;
  logic [7:0]      xor_val;

  assign xor_val     = f_reg ^ enc_reg;
  assign len_clamped = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
  assign wait_last   = (wait_cnt_reg == WAIT_END);
  assign last_byte   = ((k_reg + 1'b1) == len_reg);

`ifdef PRGA_ASCII_CHECK_EN
  logic xor_ok;
  // Acceptable plaintext: space or 'a'..'z'.
  assign xor_ok    = (xor_val == 8'd32) || ((xor_val >= 8'd97) && (xor_val <= 8'd122));
  assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE) || (state_reg == ST_FAIL);
`else
  assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
`endif

  // A start is only honoured when no decryption is running.
  assign start_ok = start && idle_like;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: fixed per-byte sequence with RD_LAT-long waits.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CALC_I: state_next = ST_RD_I;
      ST_RD_I:   state_next = ST_WAIT_I;
      ST_WAIT_I: if (wait_last) state_next = ST_RD_J;
      ST_RD_J:   state_next = ST_WAIT_J;
      ST_WAIT_J: if (wait_last) state_next = ST_WR_J;
      ST_WR_J:   state_next = ST_WR_I;
      ST_WR_I:   state_next = ST_RD_F;
      ST_RD_F:   state_next = ST_WAIT_F;
      ST_WAIT_F: if (wait_last) state_next = ST_XOR;
`ifdef PRGA_ASCII_CHECK_EN
      ST_XOR:    state_next = xor_ok ? ST_WR_D : ST_FAIL;
`else
      ST_XOR:    state_next = ST_WR_D;
`endif
      ST_WR_D:   state_next = last_byte ? ST_DONE : ST_CALC_I;
      default: begin
        // IDLE, DONE and FAIL all wait for a start; an empty message
        // completes immediately without touching any memory.
        if (start_ok) begin
          state_next = (len_clamped == '0) ? ST_DONE : ST_CALC_I;
        end
      end
    endcase
  end

  // Datapath registers: indices, captured read data and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_reg        <= '0;
      j_reg        <= '0;
      k_reg        <= '0;
      len_reg      <= '0;
      si_reg       <= '0;
      sj_reg       <= '0;
      f_reg        <= '0;
      enc_reg      <= '0;
      x_reg        <= '0;
      wait_cnt_reg <= '0;
    end else begin
      // Wait counter runs only inside WAIT_* states and rewinds on exit.
      if ((state_reg == ST_WAIT_I) || (state_reg == ST_WAIT_J) ||
          (state_reg == ST_WAIT_F)) begin
        wait_cnt_reg <= wait_last ? 3'd0 : wait_cnt_reg + 3'd1;
      end else begin
        wait_cnt_reg <= '0;
      end

      case (state_reg)
        ST_CALC_I: i_reg <= i_reg + 8'd1;
        ST_WAIT_I: begin
          if (wait_last) begin
            si_reg  <= s_rddata;
            enc_reg <= enc_rddata;
            j_reg   <= j_reg + s_rddata;
          end
        end
        ST_WAIT_J: if (wait_last) sj_reg <= s_rddata;
        ST_WAIT_F: if (wait_last) f_reg <= s_rddata;
        ST_XOR:    x_reg <= xor_val;
        ST_WR_D:   k_reg <= k_reg + 1'b1;
        default: begin
          if (start_ok) begin
            i_reg   <= '0;
            j_reg   <= '0;
            k_reg   <= '0;
            len_reg <= len_clamped;
          end
        end
      endcase
    end
  end

  // Memory-interface outputs decoded from the current state.
  // Write enables are masked by reset so a write pending in the cycle
  // reset arrives never reaches the memories.
  always_comb begin
    s_addr     = '0;
    s_wrdata   = '0;
    s_wren     = 1'b0;
    enc_addr   = '0;
    dec_addr   = '0;
    dec_wrdata = '0;
    dec_wren   = 1'b0;
    case (state_reg)
      ST_RD_I, ST_WAIT_I: begin
        s_addr   = i_reg;
        enc_addr = k_reg[MSG_AW-1:0];
      end
      ST_RD_J, ST_WAIT_J: s_addr = j_reg;
      ST_WR_J: begin
        s_addr   = j_reg;
        s_wrdata = si_reg;
        s_wren   = !reset;
      end
      ST_WR_I: begin
        s_addr   = i_reg;
        s_wrdata = sj_reg;
        s_wren   = !reset;
      end
      ST_RD_F, ST_WAIT_F: s_addr = si_reg + sj_reg;
      ST_WR_D: begin
        dec_addr   = k_reg[MSG_AW-1:0];
        dec_wrdata = x_reg;
        dec_wren   = !reset;
      end
      default: ;
    endcase
  end

  // Status outputs.
  assign busy = !idle_like;
  assign done = (state_reg == ST_DONE);
`ifdef PRGA_ASCII_CHECK_EN
  assign fail = (state_reg == ST_FAIL);
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_prga_param.sv
// Bench for rc4_prga_param: three instances with RD_LAT = 1, 2, 4 run the
// same stimulus side by side, each with its own S-box RAM, ciphertext ROM
// and plaintext RAM models. Define PRGA_ASCII_CHECK_EN to exercise the
// plaintext check.
module tb_rc4_prga_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] msg_len = '0;
  logic       load_s = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [7:0] enc_init [32];

  logic [2:0]        done_v, fail_v, busy_v, s_wren_v, any_out_v, both_v;
  logic [2:0][15:0]  s_cnt_v, dec_cnt_v, busy_cyc_v, maxa_v;
  logic [2:0][31:0]  dec4_v;
  logic [2:0][39:0]  ssel_v;

  int n_checks = 0;
  int n_errors = 0;
  int last_wait = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    logic       busy, done, fail, s_wren, dec_wren;
    logic [7:0] s_addr, s_rddata, s_wrdata, enc_rddata, dec_wrdata;
    logic [4:0] enc_addr, dec_addr;
    logic [7:0] s_mem [256];
    logic [7:0] dec_mem [32];
    logic [7:0] s_pipe [LAT];
    logic [7:0] e_pipe [LAT];
    logic [15:0] s_cnt, dec_cnt, busy_cyc, maxa;
    logic        both;

    rc4_prga_param #(.MSG_LEN_MAX(32), .MSG_AW(5), .RD_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
      .busy(busy), .done(done), .fail(fail),
      .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
      .enc_addr(enc_addr), .enc_rddata(enc_rddata),
      .dec_addr(dec_addr), .dec_wrdata(dec_wrdata), .dec_wren(dec_wren)
    );

    // Memory models: identity load on request, RD_LAT-deep read pipelines.
    always_ff @(posedge clk) begin
      if (load_s) begin
        for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
        for (int x = 0; x < 32; x++) dec_mem[x] <= 8'h00;
      end else begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        if (dec_wren) dec_mem[dec_addr] <= dec_wrdata;
      end
      s_pipe[0] <= s_mem[s_addr];
      e_pipe[0] <= enc_init[enc_addr];
      for (int n = 1; n < LAT; n++) begin
        s_pipe[n] <= s_pipe[n-1];
        e_pipe[n] <= e_pipe[n-1];
      end
    end
    assign s_rddata   = s_pipe[LAT-1];
    assign enc_rddata = e_pipe[LAT-1];

    // Activity counters.
    always_ff @(posedge clk) begin
      if (clr_cnt) begin
        s_cnt <= '0; dec_cnt <= '0; busy_cyc <= '0; maxa <= '0; both <= 1'b0;
      end else begin
        if (s_wren) s_cnt <= s_cnt + 16'd1;
        if (dec_wren) begin
          dec_cnt <= dec_cnt + 16'd1;
          if ({11'd0, dec_addr} + 16'd1 > maxa) maxa <= {11'd0, dec_addr} + 16'd1;
        end
        if (busy) busy_cyc <= busy_cyc + 16'd1;
        if (s_wren && dec_wren) both <= 1'b1;
      end
    end

    assign done_v[gi]     = done;
    assign fail_v[gi]     = fail;
    assign busy_v[gi]     = busy;
    assign s_wren_v[gi]   = s_wren;
    assign both_v[gi]     = both;
    assign any_out_v[gi]  = |{s_addr, s_wrdata, s_wren, enc_addr, dec_addr,
                              dec_wrdata, dec_wren, busy, done, fail};
    assign s_cnt_v[gi]    = s_cnt;
    assign dec_cnt_v[gi]  = dec_cnt;
    assign busy_cyc_v[gi] = busy_cyc;
    assign maxa_v[gi]     = maxa;
    assign dec4_v[gi]     = {dec_mem[3], dec_mem[2], dec_mem[1], dec_mem[0]};
    assign ssel_v[gi]     = {s_mem[9], s_mem[5], s_mem[4], s_mem[3], s_mem[2]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until every instance reports done or fail.
  task automatic wait_finish();
    last_wait = 0;
    while (!(&(done_v | fail_v)) && last_wait < 3000) begin
      @(negedge clk);
      last_wait++;
    end
    check("finish_timeout", 64'(last_wait >= 3000), 64'd0);
  endtask

  // Reload S with identity, clear counters, pulse start, wait for the end.
  task automatic run_len(input int len);
    @(negedge clk);
    load_s = 1'b1; clr_cnt = 1'b1;
    @(negedge clk);
    load_s = 1'b0; clr_cnt = 1'b0;
    msg_len = 6'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish();
  endtask

  typedef struct {
    int len;
    int exp_bytes;
    int exp_s_wr;
    int exp_maxa;
  } vec_t;

  vec_t vecs [5];

  initial begin
    for (int x = 0; x < 32; x++) enc_init[x] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(any_out_v), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", 64'(any_out_v), 64'd0);

    // Empty message: done within 3 cycles, no writes at all.
    run_len(0);
    $display("txn len=0 wait=%0d done=%b s_wr=%0d dec_wr=%0d", last_wait, done_v,
             s_cnt_v[1], dec_cnt_v[1]);
    check("len0_wait", 64'(last_wait <= 3), 64'd1);
    check("len0_done", 64'(done_v), 64'h7);
    for (int g = 0; g < 3; g++) begin
      check("len0_s_wr", 64'(s_cnt_v[g]), 64'd0);
      check("len0_dec_wr", 64'(dec_cnt_v[g]), 64'd0);
    end

`ifndef PRGA_ASCII_CHECK_EN
    vecs[0] = '{len: 4,  exp_bytes: 4,  exp_s_wr: 8,  exp_maxa: 4};
    vecs[1] = '{len: 1,  exp_bytes: 1,  exp_s_wr: 2,  exp_maxa: 1};
    vecs[2] = '{len: 40, exp_bytes: 32, exp_s_wr: 64, exp_maxa: 32};
    vecs[3] = '{len: 32, exp_bytes: 32, exp_s_wr: 64, exp_maxa: 32};
    vecs[4] = '{len: 4,  exp_bytes: 4,  exp_s_wr: 8,  exp_maxa: 4};

    for (int v = 0; v < 5; v++) begin
      run_len(vecs[v].len);
      $display("txn vec=%0d len=%0d done=%b dec_wr=%0d,%0d,%0d busy=%0d,%0d,%0d",
               v, vecs[v].len, done_v, dec_cnt_v[0], dec_cnt_v[1], dec_cnt_v[2],
               busy_cyc_v[0], busy_cyc_v[1], busy_cyc_v[2]);
      for (int g = 0; g < 3; g++) begin
        int lat;
        lat = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        check("vec_done", 64'(done_v[g]), 64'd1);
        check("vec_fail", 64'(fail_v[g]), 64'd0);
        check("vec_dec_wr", 64'(dec_cnt_v[g]), 64'(vecs[v].exp_bytes));
        check("vec_s_wr", 64'(s_cnt_v[g]), 64'(vecs[v].exp_s_wr));
        check("vec_max_addr", 64'(maxa_v[g]), 64'(vecs[v].exp_maxa));
        check("vec_busy_cyc", 64'(busy_cyc_v[g]), 64'(vecs[v].exp_bytes * (8 + 3 * lat)));
        check("vec_no_overlap", 64'(both_v[g]), 64'd0);
      end
    end

    // Last vector was the 4-byte identity case: check plaintext and S.
    for (int g = 0; g < 3; g++) begin
      check("l4_dec", 64'(dec4_v[g]), 64'h0D070502);
      check("l4_sbox", 64'(ssel_v[g]), 64'h0402090503);
    end
    check("lat_delta", 64'(busy_cyc_v[2] - busy_cyc_v[0]), 64'd36);

    // Start while busy must be ignored.
    @(negedge clk);
    load_s = 1'b1; clr_cnt = 1'b1;
    @(negedge clk);
    load_s = 1'b0; clr_cnt = 1'b0;
    msg_len = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    msg_len = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish();
    $display("txn busy_start done=%b dec_wr=%0d", done_v, dec_cnt_v[1]);
    for (int g = 0; g < 3; g++) begin
      check("ign_dec_wr", 64'(dec_cnt_v[g]), 64'd4);
      check("ign_dec", 64'(dec4_v[g]), 64'h0D070502);
    end

    // Reset during WR_J of byte 2 (the fifth S write) on the RD_LAT=2 copy.
    @(negedge clk);
    load_s = 1'b1; clr_cnt = 1'b1;
    @(negedge clk);
    load_s = 1'b0; clr_cnt = 1'b0;
    msg_len = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!(s_wren_v[1] && s_cnt_v[1] == 16'd4) && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
      check("rst_wrj_timeout", 64'(cyc >= 500), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", 64'(any_out_v), 64'd0);
    check("rst_s_wr", 64'(s_cnt_v[1]), 64'd4);
    check("rst_dec_wr", 64'(dec_cnt_v[1]), 64'd2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn mid_reset s_wr=%0d dec_wr=%0d outs=%b", s_cnt_v[1], dec_cnt_v[1], any_out_v);
    check("rst_after_s_wr", 64'(s_cnt_v[1]), 64'd4);
    check("rst_after_idle", 64'(any_out_v), 64'd0);
    run_len(4);
    $display("txn after_reset dec=%h", dec4_v[1]);
    for (int g = 0; g < 3; g++) begin
      check("rerun_dec", 64'(dec4_v[g]), 64'h0D070502);
      check("rerun_sbox", 64'(ssel_v[g]), 64'h0402090503);
    end
`else
    // Byte 0 decrypts to 'a', byte 1 to 0x05 which aborts.
    enc_init[0] = 8'h63;
    run_len(4);
    $display("txn ascii fail=%b done=%b dec_wr=%0d dec0=%h", fail_v, done_v,
             dec_cnt_v[1], dec4_v[1][7:0]);
    for (int g = 0; g < 3; g++) begin
      check("ascii_fail", 64'(fail_v[g]), 64'd1);
      check("ascii_done", 64'(done_v[g]), 64'd0);
      check("ascii_dec_wr", 64'(dec_cnt_v[g]), 64'd1);
      check("ascii_dec0", 64'(dec4_v[g][7:0]), 64'h61);
    end
    enc_init[0] = 8'h00;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
